// File: rtl/color_pkg.sv
// ============================================================================
// Module  : color_pkg
// Brief   : Shared types and constants for the colour descrambler datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package color_pkg;

    typedef logic [23:0] pixel_t;
    typedef logic [7:0]  chan_t;
    typedef logic [1:0]  src_idx_t;

    localparam logic [3:0]  SEL_R        = 4'd0;
    localparam logic [3:0]  SEL_G        = 4'd1;
    localparam logic [3:0]  SEL_B        = 4'd2;
    localparam logic [3:0]  SEL_ZERO     = 4'd3;
    localparam src_idx_t    SRC_LOST     = 2'd3;
    localparam logic [11:0] IDENTITY_MAP = 12'h012;

    // Select one 8-bit slot of a {R,G,B} pixel; a lost index reads as zero.
    function automatic chan_t pick_chan(input pixel_t pix, input src_idx_t idx);
        chan_t c;
        case (idx)
            2'd0:    c = pix[23:16];
            2'd1:    c = pix[15:8];
            2'd2:    c = pix[7:0];
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/descramble_map_decode.sv
// ============================================================================
// Module  : descramble_map_decode
// Brief   : Turns three scrambler select codes into per-channel source slots.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module descramble_map_decode
    import color_pkg::*;
(
    input  logic [3:0] i_sel_r,
    input  logic [3:0] i_sel_g,
    input  logic [3:0] i_sel_b,
    output src_idx_t   o_src_r,
    output src_idx_t   o_src_g,
    output src_idx_t   o_src_b
);

    // Lowest slot (R, then G, then B) carrying original channel `code`.
    function automatic src_idx_t find_slot(input logic [3:0] code,
                                           input logic [3:0] r,
                                           input logic [3:0] g,
                                           input logic [3:0] b);
        src_idx_t s;
        if (r == code)      s = 2'd0;
        else if (g == code) s = 2'd1;
        else if (b == code) s = 2'd2;
        else                s = SRC_LOST;
        return s;
    endfunction

    assign o_src_r = find_slot(SEL_R, i_sel_r, i_sel_g, i_sel_b);
    assign o_src_g = find_slot(SEL_G, i_sel_r, i_sel_g, i_sel_b);
    assign o_src_b = find_slot(SEL_B, i_sel_r, i_sel_g, i_sel_b);

endmodule

`default_nettype wire

// File: rtl/color_descrambler.sv
// ============================================================================
// Module  : color_descrambler
// Brief   : 2-stage streaming inverse of the per-channel colour scrambler.
//           Option macro COLOR_DESCRAMBLER_LOST_COPY_EN fills lost channels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module color_descrambler
    import color_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       swR,
    input  logic [3:0]       swG,
    input  logic [3:0]       swB,
    input  logic             cfg_load,
    input  logic             cnt_clr,
    input  logic [23:0]      s_pixel,
    input  logic             s_sof,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [23:0]      m_pixel,
    output logic             m_sof,
    output logic [2:0]       m_lost,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [11:0]      cfg_active,
    output logic [CNT_W-1:0] lost_count
);

    logic [11:0] r_active;
    logic [11:0] r_pending;
    logic        r_pend_flag;

    logic        r_s1_valid;
    pixel_t      r_s1_pixel;
    logic        r_s1_sof;
    src_idx_t    r_s1_src_r, r_s1_src_g, r_s1_src_b;

    logic        w_en;
    logic        w_accept;
    logic        w_apply;
    logic [11:0] w_map;
    src_idx_t    w_src_r, w_src_g, w_src_b;
    chan_t       w_chan_r, w_chan_g, w_chan_b;
    logic [2:0]  w_lost;
    pixel_t      w_out;

    assign w_en     = !m_valid || m_ready;
    assign s_ready  = w_en;
    assign w_accept = s_valid && w_en;
    // A pending map takes effect on the sof beat itself, not the one after.
    assign w_apply  = w_accept && s_sof && r_pend_flag;
    assign w_map    = w_apply ? r_pending : r_active;

    assign cfg_active = r_active;

    descramble_map_decode u_decode (
        .i_sel_r (w_map[11:8]),
        .i_sel_g (w_map[7:4]),
        .i_sel_b (w_map[3:0]),
        .o_src_r (w_src_r),
        .o_src_g (w_src_g),
        .o_src_b (w_src_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active    <= IDENTITY_MAP;
            r_pending   <= IDENTITY_MAP;
            r_pend_flag <= 1'b0;
        end else begin
            if (w_apply) begin
                r_active <= r_pending;
            end
            if (cfg_load) begin
                r_pending   <= {swR, swG, swB};
                r_pend_flag <= 1'b1;
            end else if (w_apply) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_pixel <= '0;
            r_s1_sof   <= 1'b0;
            r_s1_src_r <= 2'd0;
            r_s1_src_g <= 2'd1;
            r_s1_src_b <= 2'd2;
        end else if (w_en) begin
            r_s1_valid <= s_valid;
            if (s_valid) begin
                r_s1_pixel <= s_pixel;
                r_s1_sof   <= s_sof;
                r_s1_src_r <= w_src_r;
                r_s1_src_g <= w_src_g;
                r_s1_src_b <= w_src_b;
            end
        end
    end

    assign w_chan_r = pick_chan(r_s1_pixel, r_s1_src_r);
    assign w_chan_g = pick_chan(r_s1_pixel, r_s1_src_g);
    assign w_chan_b = pick_chan(r_s1_pixel, r_s1_src_b);
    assign w_lost   = {r_s1_src_r == SRC_LOST, r_s1_src_g == SRC_LOST, r_s1_src_b == SRC_LOST};

`ifdef COLOR_DESCRAMBLER_LOST_COPY_EN
    chan_t w_fill;

    always_comb begin
        w_fill = 8'h00;
        if (!w_lost[2])      w_fill = w_chan_r;
        else if (!w_lost[1]) w_fill = w_chan_g;
        else if (!w_lost[0]) w_fill = w_chan_b;
    end

    assign w_out = {w_lost[2] ? w_fill : w_chan_r,
                    w_lost[1] ? w_fill : w_chan_g,
                    w_lost[0] ? w_fill : w_chan_b};
`else
    assign w_out = {w_chan_r, w_chan_g, w_chan_b};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pixel <= '0;
            m_sof   <= 1'b0;
            m_lost  <= '0;
        end else if (w_en) begin
            m_valid <= r_s1_valid;
            if (r_s1_valid) begin
                m_pixel <= w_out;
                m_sof   <= r_s1_sof;
                m_lost  <= w_lost;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_count <= '0;
        end else if (cnt_clr) begin
            lost_count <= '0;
        end else if (m_valid && m_ready && (|m_lost) && (lost_count != {CNT_W{1'b1}})) begin
            lost_count <= lost_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
